// File: rtl/mem_arbiter_4_1.sv
// mem_arbiter_4_1: four initiators share one native-bus target port.
// Round-robin arbitration picks one initiator, which keeps the grant
// until its transaction completes. A watchdog ends any transaction the
// target never acknowledges and returns ERR_DATA.
module mem_arbiter_4_1 #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_mem_valid0,
  input  logic        s_mem_valid1,
  input  logic        s_mem_valid2,
  input  logic        s_mem_valid3,
  output logic        s_mem_ready0,
  output logic        s_mem_ready1,
  output logic        s_mem_ready2,
  output logic        s_mem_ready3,
  input  logic [31:0] s_mem_addr0,
  input  logic [31:0] s_mem_addr1,
  input  logic [31:0] s_mem_addr2,
  input  logic [31:0] s_mem_addr3,
  input  logic [31:0] s_mem_wdata0,
  input  logic [31:0] s_mem_wdata1,
  input  logic [31:0] s_mem_wdata2,
  input  logic [31:0] s_mem_wdata3,
  input  logic [3:0]  s_mem_wstrb0,
  input  logic [3:0]  s_mem_wstrb1,
  input  logic [3:0]  s_mem_wstrb2,
  input  logic [3:0]  s_mem_wstrb3,
  output logic [31:0] s_mem_rdata0,
  output logic [31:0] s_mem_rdata1,
  output logic [31:0] s_mem_rdata2,
  output logic [31:0] s_mem_rdata3,
  output logic        m_mem_valid,
  input  logic        m_mem_ready,
  output logic [31:0] m_mem_addr,
  output logic [31:0] m_mem_wdata,
  output logic [3:0]  m_mem_wstrb,
  input  logic [31:0] m_mem_rdata,
  input  logic        err_clear,
  output logic        err_timeout,
  output logic [1:0]  err_master_id
);

  // A zero TIMEOUT_CYCLES disables the watchdog; keep the counter 1 bit wide then.
  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_TIMEOUT = 2'd2;

  logic [1:0]    state;
  logic [1:0]    grant;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;

  logic [3:0]  req;
  logic [31:0] addr_a  [4];
  logic [31:0] wdata_a [4];
  logic [3:0]  wstrb_a [4];
  logic [3:0]  rdy_v;
  logic [31:0] rdata_a [4];

  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;
  logic       busy;
  logic       tmo;
  logic       timeout_hit;

  assign req = {s_mem_valid3, s_mem_valid2, s_mem_valid1, s_mem_valid0};

  // Gather the per-initiator request fields into indexable arrays.
  always_comb begin
    addr_a[0]  = s_mem_addr0;  addr_a[1]  = s_mem_addr1;
    addr_a[2]  = s_mem_addr2;  addr_a[3]  = s_mem_addr3;
    wdata_a[0] = s_mem_wdata0; wdata_a[1] = s_mem_wdata1;
    wdata_a[2] = s_mem_wdata2; wdata_a[3] = s_mem_wdata3;
    wstrb_a[0] = s_mem_wstrb0; wstrb_a[1] = s_mem_wstrb1;
    wstrb_a[2] = s_mem_wstrb2; wstrb_a[3] = s_mem_wstrb3;
  end

  // Round-robin pick: first requester scanning ptr, ptr+1, ... (wraps mod 4).
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign busy        = (state == S_BUSY);
  assign tmo         = (state == S_TIMEOUT);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Target-side request: forwarded from the granted initiator only while BUSY.
  always_comb begin
    m_mem_valid = busy & req[grant];
    m_mem_addr  = busy ? addr_a[grant]  : 32'h0;
    m_mem_wdata = busy ? wdata_a[grant] : 32'h0;
    m_mem_wstrb = busy ? wstrb_a[grant] : 4'h0;
  end

  // Initiator-side response: only the granted lane ever sees ready/rdata.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rdy_v[k]   = 1'b0;
      rdata_a[k] = 32'h0;
      if (grant == 2'(k)) begin
        if (busy) begin
          rdy_v[k]   = m_mem_ready;
          rdata_a[k] = m_mem_rdata;
        end else if (tmo) begin
          rdy_v[k]   = 1'b1;
          rdata_a[k] = ERR_DATA;
        end
      end
    end
  end

  assign s_mem_ready0 = rdy_v[0];
  assign s_mem_ready1 = rdy_v[1];
  assign s_mem_ready2 = rdy_v[2];
  assign s_mem_ready3 = rdy_v[3];
  assign s_mem_rdata0 = rdata_a[0];
  assign s_mem_rdata1 = rdata_a[1];
  assign s_mem_rdata2 = rdata_a[2];
  assign s_mem_rdata3 = rdata_a[3];

  // Arbitration FSM: grant is locked from IDLE until completion, drop or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= 2'd0;
      grant <= 2'd0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant <= pick;
            cnt   <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Target completion beats both the valid drop and the watchdog.
          if (m_mem_ready) begin
            ptr   <= grant + 2'd1;
            state <= S_IDLE;
          end else if (!req[grant]) begin
            // Initiator abandoned its request: release without moving ptr.
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (timeout_hit) state <= S_TIMEOUT;
          end
        end
        S_TIMEOUT: begin
          ptr   <= grant + 2'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky timeout flag; a timeout in the same cycle as err_clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout   <= 1'b0;
      err_master_id <= 2'd0;
    end else if (tmo) begin
      err_timeout   <= 1'b1;
      err_master_id <= grant;
    end else if (err_clear) begin
      err_timeout   <= 1'b0;
    end
  end

endmodule

// File: doc/mem_arbiter_4_1.md
# mem_arbiter_4_1

Four-initiator to one-target arbiter for the native memory bus (valid/ready/addr/wdata/wstrb/rdata), the converging counterpart to the address-decoding fan-out in the interconnect. It lets the CPU, the AES engine's DMA port and two spare initiators share one target port, normally the interconnect's slave side. Arbitration is round-robin with a locked grant that is held until the transaction completes. A watchdog terminates any transaction the target never acknowledges, returning an error word and a sticky error flag.

## Interface
- TIMEOUT_CYCLES, 1024: number of BUSY cycles without target ready before forced termination; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF: read data returned on a timeout.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- s_mem_valid{0..3}  in  1  request from initiator k.
- s_mem_ready{0..3}  out  1  one-cycle completion pulse to initiator k.
- s_mem_addr{0..3}  in  32  address from initiator k.
- s_mem_wdata{0..3}  in  32  write data from initiator k.
- s_mem_wstrb{0..3}  in  4  byte strobes from initiator k; 0 means read.
- s_mem_rdata{0..3}  out  32  read data to initiator k.
- m_mem_valid  out  1  request to the target.
- m_mem_ready  in  1  target completion.
- m_mem_addr, m_mem_wdata  out  32  forwarded from the granted initiator.
- m_mem_wstrb  out  4  forwarded from the granted initiator.
- m_mem_rdata  in  32  target read data.
- err_clear  in  1  clears err_timeout.
- err_timeout  out  1  sticky flag, set on any timeout.
- err_master_id  out  2  initiator index of the most recent timeout.

## Operation
- States: IDLE, BUSY, TIMEOUT. Registered state: grant[1:0], ptr[1:0] (highest-priority index), cnt (watchdog counter, width clog2(TIMEOUT_CYCLES+1)).
- **IDLE**
  - m_mem_valid=0; all m_mem_addr/wdata/wstrb=0; all s_mem_ready=0.
  - If any s_mem_valid is high, grant = first requester searching ptr, ptr+1, … mod 4. Then cnt<=0 and go to BUSY.
- **BUSY**
  - m_mem_valid = s_mem_valid[grant]; addr/wdata/wstrb are combinationally muxed from the granted initiator.
  - s_mem_ready[grant] = m_mem_ready and s_mem_rdata[grant] = m_mem_rdata, both combinational.
  - On m_mem_ready: ptr<=grant+1 mod 4, go to IDLE.
  - If the granted s_mem_valid drops without m_mem_ready (protocol violation): go to IDLE; ptr is unchanged; no ready pulse is issued.
  - Otherwise cnt increments. If TIMEOUT_CYCLES!=0 and cnt==TIMEOUT_CYCLES-1, go to TIMEOUT.
- **TIMEOUT** (one cycle)
  - m_mem_valid=0; s_mem_ready[grant]=1 with s_mem_rdata[grant]=ERR_DATA.
  - err_timeout<=1, err_master_id<=grant, ptr<=grant+1, then go to IDLE.
- Outputs for non-granted initiators: s_mem_ready=0 and s_mem_rdata=0 in every state.
- Error flag: err_clear clears err_timeout in the following cycle. If a timeout and err_clear occur in the same cycle, the set wins.
- Initiators must hold valid and all request fields stable until their ready pulse. After the ready pulse they may re-assert valid in the next cycle.

## Timing
- Reset values (with rst high at an edge): state=IDLE, ptr=0, grant=0, cnt=0, err_timeout=0, err_master_id=0. Consequently m_mem_valid=0 and every s_mem_ready=0 in the next cycle. Reset in BUSY or TIMEOUT abandons the transaction with no ready pulse.
- Arbitration latency: a request first seen in IDLE at cycle 0 gives m_mem_valid=1 at cycle 1. If the target is zero-wait and ready at cycle 1, s_mem_ready pulses at cycle 1.
- After completion at cycle N, the state is IDLE at N+1 and the next grant's m_mem_valid rises at N+2. The minimum per-transaction period is 2 cycles.
- Timeout: m_mem_valid is high for exactly TIMEOUT_CYCLES cycles. The error ready pulse occurs in the cycle after the last of those cycles.
- If m_mem_ready arrives in the final BUSY cycle, normal completion wins and no timeout occurs.
- The grant never changes while in BUSY, regardless of other requests.

## Test plan
- **Single read.** Initiator 2 reads 0x20000010; the target asserts ready 3 cycles after m_mem_valid with rdata 0x12345678. Required: m_mem_valid rises 1 cycle after the request, m_mem_addr=0x20000010, s_mem_ready2 pulses once with 0x12345678, ptr=3, no other s_mem_ready asserts.
- **Round-robin fairness.** All four initiators request continuously from reset with a 1-wait target. Required: grant order 0,1,2,3,0,…; each initiator completes exactly once per 4 transactions.
- **Write isolation.** Initiator 1 writes 0xA5A5A5A5 to 0x28000004 with wstrb 4'b0011 while initiator 3 is also requesting. Required: the target sees exactly initiator 1's addr/wdata/wstrb for the whole transaction; initiator 3 is granted next with its own fields.
- **Watchdog.** TIMEOUT_CYCLES=8, initiator 0 requests, target ready held low. Required: 8 cycles of m_mem_valid, then s_mem_ready0 pulses with rdata 0xDEADBEEF, err_timeout=1, err_master_id=0, ptr=1. A later err_clear pulse gives err_timeout=0.
- **Mid-transaction reset.** rst is asserted in the 2nd BUSY cycle of a request from initiator 3. Required: the next cycle has m_mem_valid=0, no s_mem_ready3 pulse, ptr=0, err_timeout=0; the re-issued request is served normally.
- **Valid drop.** Initiator 1 is granted, then deasserts valid before the target is ready. Required: the state returns to IDLE, ptr is unchanged, no ready pulse is issued, err_timeout stays 0.
